bfloat16_row_norm: RTL

Sequential front-end for `bfloat16_div` in the normalisation (softmax-style) path. It accepts a stream of non-negative bfloat16 elements, buffers up to DEPTH of them, and accumulates their sum. It then replays each buffered element against the sum into the combinational divider (`a` = element, `b` = sum), registering each quotient onto a valid/ready output stream. One input vector produces one output vector of equal length.

---
 rtl/bfloat16_row_norm.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bfloat16_row_norm.sv
// bfloat16_row_norm
// Buffers a vector of non-negative bfloat16 elements while accumulating
// their sum with a truncating bfloat16 adder. It then replays every buffered
// element against the sum through an external combinational bfloat16_div
// and registers each quotient onto a valid/ready output stream.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input element handshake (ready only while accumulating)
//   in_data, in_last    bfloat16 element and end-of-vector marker
//   div_a, div_b        element / sum presented to the divider (0 while accumulating)
//   div_result          combinational quotient returned by the divider
//   out_valid/out_ready output quotient handshake
//   out_data, out_last  registered quotient and end-of-vector marker
//   ovf                 current/last vector was cut off at DEPTH elements
module bfloat16_row_norm #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ACCUM, PRIME, EMIT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] elem;
  logic             accept;
  logic             vec_end;
  logic             trunc;
  logic             emit_hs;

  // Truncating bfloat16 add of two non-negative operands (sign bits dropped).
  // exp==0 counts as zero; any infinity, or an exponent overflow, saturates
  // to +inf, which then stays put because inf is absorbing here.
  function automatic logic [15:0] acc_add(input logic [14:0] x, input logic [14:0] y);
    logic [7:0] ex;
    logic [7:0] ey;
    logic [7:0] e_big;
    logic [7:0] d;
    logic [7:0] m_big;
    logic [7:0] m_sml;
    logic [7:0] m_sh;
    logic [8:0] m_sum;
    logic [7:0] e_out;
    logic [6:0] f_out;
    ex = x[14:7];
    ey = y[14:7];
    if (ex == 8'hFF || ey == 8'hFF) return 16'h7F80;
    if (ex == 8'h00) return (ey == 8'h00) ? 16'h0000 : {1'b0, y};
    if (ey == 8'h00) return {1'b0, x};
    if (ex >= ey) begin
      e_big = ex;
      d     = ex - ey;
      m_big = {1'b1, x[6:0]};
      m_sml = {1'b1, y[6:0]};
    end else begin
      e_big = ey;
      d     = ey - ex;
      m_big = {1'b1, y[6:0]};
      m_sml = {1'b1, x[6:0]};
    end
    // A shift of 8 or more empties the 8-bit mantissa entirely.
    m_sh  = (d >= 8'd8) ? 8'd0 : (m_sml >> d);
    m_sum = {1'b0, m_big} + {1'b0, m_sh};
    if (m_sum[8]) begin
      e_out = e_big + 8'd1;
      f_out = m_sum[7:1];
    end else begin
      e_out = e_big;
      f_out = m_sum[6:0];
    end
    if (e_out == 8'hFF) return 16'h7F80;
    return {1'b0, e_out, f_out};
  endfunction

  assign elem     = in_data & 16'h7FFF;
  assign in_ready = (state == ACCUM);
  assign accept   = in_valid & in_ready;
  assign vec_end  = in_last | (count == CW'(DEPTH - 1));
  // Only a forced stop at DEPTH counts as truncation; an explicit last wins.
  assign trunc    = (count == CW'(DEPTH - 1)) & ~in_last;
  assign emit_hs  = (state == EMIT) & out_valid & out_ready;
  assign div_a    = in_ready ? '0 : mem[rd_ptr];
  assign div_b    = in_ready ? '0 : sum;

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && vec_end) state_nxt = PRIME;
      PRIME:   state_nxt = EMIT;
      EMIT:    if (emit_hs && out_last) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Element buffer: data only, never reset.
  always_ff @(posedge clk) begin
    if (accept) mem[count[AW-1:0]] <= elem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      sum       <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        // Accumulate: store element, fold it into the running sum.
        ACCUM: begin
          if (accept) begin
            count <= count + CW'(1);
            sum   <= acc_add(sum[14:0], elem[14:0]);
            if (trunc)              ovf <= 1'b1;
            else if (count == '0)   ovf <= 1'b0;
            if (vec_end) rd_ptr <= '0;
          end
        end
        // Prime: capture the first quotient, point at the second element.
        PRIME: begin
          out_data  <= div_result;
          out_valid <= 1'b1;
          out_last  <= (count == CW'(1));
          rd_ptr    <= AW'(1);
        end
        // Emit: advance one quotient per output handshake.
        EMIT: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              count     <= '0;
              sum       <= '0;
              rd_ptr    <= '0;
            end else begin
              out_data <= div_result;
              rd_ptr   <= rd_ptr + AW'(1);
              out_last <= ({1'b0, rd_ptr} == count - CW'(1));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
